// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu - load/store unit for the veriRISCV core.
//
// Takes load/store requests from the EX stage and drives an Avalon-MM data
// master. Bus requests are combinational from the EX inputs. Load responses
// are lane-selected and sign/zero-extended, then returned to the MEM stage
// as a one-cycle lsu_readdatavalid pulse.
//
// Optional feature macro: LSU_MISALIGN_CHECK_EN
//   defined   : misaligned H/W accesses are blocked and raise an exception flag.
//   undefined : every access is issued. Byte enables are truncated to 4 bits.
//               Missing upper load bytes read as 0.
//
// Ports
//   clk, rst                  core clock, synchronous active-high reset
//   ex_mem_read/write         valid load/store held in EX
//   ex_mem_opcode             funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   ex_mem_address            byte address
//   ex_mem_writedata          store data (rs2)
//   ex_flush                  EX instruction is being killed
//   lsu_readdatavalid/data    extended load result to MEM
//   lsu_ex_stall              request issued but not accepted
//   lsu_mem_stall             load response still pending
//   lsu_exc_*_misaligned      misaligned access flags (combinational)
//   avm_*                     Avalon-MM data master
// ---------------------------------------------------------------------------
module lsu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [2:0]        ex_mem_opcode,
  input  logic [ADDR_W-1:0] ex_mem_address,
  input  logic [DATA_W-1:0] ex_mem_writedata,
  input  logic              ex_flush,
  output logic              lsu_readdatavalid,
  output logic [DATA_W-1:0] lsu_readdata,
  output logic              lsu_ex_stall,
  output logic              lsu_mem_stall,
  output logic              lsu_exc_load_misaligned,
  output logic              lsu_exc_store_misaligned,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid,
  input  logic [DATA_W-1:0] avm_readdata
);

  typedef enum logic [1:0] {IDLE, WAIT_RDATA, DRAIN} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  opcode_reg;
  logic [1:0]  offset_reg;

  logic [1:0]        offset;
  logic [1:0]        size;
  logic              misaligned;
  logic              can_issue;
  logic              req_ok;
  logic              load_accept;
  logic              resp_fire;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] formatted;

  assign offset = ex_mem_address[1:0];
  assign size   = ex_mem_opcode[1:0];

`ifdef LSU_MISALIGN_CHECK_EN
  assign misaligned = ((size == 2'b01) && offset[0]) ||
                      ((size == 2'b10) && (offset != 2'b00));
  assign lsu_exc_load_misaligned  = ex_mem_read & ~ex_flush & misaligned;
  assign lsu_exc_store_misaligned = ex_mem_write & ~ex_flush & misaligned;
`else
  assign misaligned               = 1'b0;
  assign lsu_exc_load_misaligned  = 1'b0;
  assign lsu_exc_store_misaligned = 1'b0;
`endif

  // A new request may go out when idle, or in the same cycle the outstanding
  // load returns, which gives back-to-back loads with no bubble.
  assign can_issue = (state_reg == IDLE) ||
                     ((state_reg == WAIT_RDATA) && avm_readdatavalid);
  assign req_ok    = ~rst & ~ex_flush & ~misaligned & can_issue;

  // Loads take priority if EX ever presents both flags.
  assign avm_read    = ex_mem_read & req_ok;
  assign avm_write   = ex_mem_write & ~ex_mem_read & req_ok;
  assign avm_address = {ex_mem_address[ADDR_W-1:2], 2'b00};

  // Shifts of 4-bit constants drop lanes beyond byte 3 on purpose.
  always_comb begin
    avm_byteenable = 4'b1111;
    avm_writedata  = ex_mem_writedata;
    case (size)
      2'b00: begin
        avm_byteenable = 4'b0001 << offset;
        avm_writedata  = {4{ex_mem_writedata[7:0]}};
      end
      2'b01: begin
        avm_byteenable = 4'b0011 << offset;
        avm_writedata  = {2{ex_mem_writedata[15:0]}};
      end
      default: ;
    endcase
  end

  assign lsu_ex_stall = (avm_read | avm_write) & avm_waitrequest;
  assign load_accept  = avm_read & ~avm_waitrequest;

  // Logical right shift brings the addressed lane to bit 0 and zero-fills
  // any bytes that would lie past the end of the word.
  assign shifted = avm_readdata >> {offset_reg, 3'b000};

  always_comb begin
    formatted = shifted;
    case (opcode_reg)
      3'b000:  formatted = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      3'b001:  formatted = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      3'b100:  formatted = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      3'b101:  formatted = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      default: formatted = shifted;
    endcase
  end

  // Responses are only honoured while a load is outstanding; DRAIN consumes
  // its response silently.
  assign resp_fire         = ~rst & (state_reg == WAIT_RDATA) & avm_readdatavalid;
  assign lsu_readdatavalid = resp_fire;
  assign lsu_readdata      = resp_fire ? formatted : '0;
  assign lsu_mem_stall     = ~rst & (((state_reg == WAIT_RDATA) & ~avm_readdatavalid) |
                                     (state_reg == DRAIN));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:       if (load_accept) state_next = WAIT_RDATA;
      WAIT_RDATA: if (avm_readdatavalid) state_next = load_accept ? WAIT_RDATA : IDLE;
      DRAIN:      if (avm_readdatavalid) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      opcode_reg <= 3'b000;
      offset_reg <= 2'b00;
    end else begin
      state_reg <= state_next;
      if (load_accept) begin
        opcode_reg <= ex_mem_opcode;
        offset_reg <= offset;
      end
    end
  end

endmodule
